// File: rtl/pe_pkg.sv
// pe_pkg: shared code/word types and the 2-to-4 decode function for the priority-encoder link.
package pe_pkg;
  localparam int PE_N_OUT = 4;
  localparam int PE_IDX_W = 2;
  typedef logic [PE_IDX_W-1:0] pe_code_t;
  typedef struct packed {
    logic [PE_N_OUT-1:0] line;
    logic                none;
  } pe_dec_word_t;
  function automatic pe_dec_word_t pe_decode(input pe_code_t code, input logic v);
    pe_decode.line = v ? PE_N_OUT'(1) << code : '0;
    pe_decode.none = !v;
  endfunction
endpackage

// File: rtl/pe_dec_skid.sv
// pe_dec_skid: 1-entry skid buffer with registered output over pe_dec_word_t.
module pe_dec_skid
  import pe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  pe_dec_word_t in_data,
  output logic         in_ready,
  output logic         out_valid,
  output pe_dec_word_t out_data,
  input  logic         out_ready
);
  logic         skid_full;
  pe_dec_word_t skid_data;
  logic         in_xfer;
  assign in_ready = !skid_full;
  assign in_xfer  = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (out_ready || !out_valid) begin
      // A full skid blocks input, so it can drain here without racing a new word.
      if (skid_full) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else begin
        out_valid <= in_xfer;
        if (in_xfer) out_data <= in_data;
      end
    end else if (in_xfer) begin
      skid_full <= 1'b1;
      skid_data <= in_data;
    end
  end
endmodule

// File: rtl/pe_decoder_stream.sv
// pe_decoder_stream: streaming 2-to-4 decoder with skid buffer; hit counters under PE_DEC_HIT_CNT_EN.
module pe_decoder_stream
  import pe_pkg::*;
#(
  parameter int N_OUT = PE_N_OUT,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_y1,
  input  logic               in_y0,
  input  logic               in_v,
  output logic               in_ready,
  output logic               out_valid,
  output logic [N_OUT-1:0]   out_line,
  output logic               out_none,
  input  logic               out_ready,
  input  logic               cnt_clr,
  output logic [5*CNT_W-1:0] hit_cnt
);
  pe_dec_word_t dec_word, out_word;
  assign dec_word = pe_decode({in_y1, in_y0}, in_v);
  pe_dec_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (dec_word),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_word),
    .out_ready(out_ready)
  );
  assign out_line = out_word.line;
  assign out_none = out_word.none;
`ifdef PE_DEC_HIT_CNT_EN
  logic [CNT_W-1:0] cnt [5];
  logic [4:0]       hit;
  assign hit = {out_none, out_line} & {5{out_valid && out_ready}};
  always_ff @(posedge clk) begin
    for (int k = 0; k < 5; k++)
      if (rst || cnt_clr) cnt[k] <= '0;
      else if (hit[k] && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
  end
  for (genvar g = 0; g < 5; g++) begin : g_cnt
    assign hit_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign hit_cnt = '0;
`endif
endmodule

// File: tb/tb_pe_decoder_stream.sv
// tb_pe_decoder_stream: directed self-checking bench for pe_decoder_stream (counters with PE_DEC_HIT_CNT_EN).
module tb_pe_decoder_stream;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0, in_y1 = 0, in_y0 = 0, in_v = 0;
  logic        in_ready, out_valid, out_none;
  logic [3:0]  out_line;
  logic        out_ready = 1;
  logic        cnt_clr = 0;
  logic [39:0] hit_cnt;
  int checks = 0, failures = 0;
  logic [3:0] exp_line [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  pe_decoder_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_y1(in_y1), .in_y0(in_y0),
    .in_v(in_v), .in_ready(in_ready), .out_valid(out_valid), .out_line(out_line),
    .out_none(out_none), .out_ready(out_ready), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input int code);
    in_valid = 1;
    in_v = v;
    {in_y1, in_y0} = 2'(code);
  endtask

  task automatic test_reset();
    rst = 1; out_ready = 1; in_valid = 0;
    step(); step();
    rst = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_line !== 4'b0000) begin failures++; $display("FAIL reset_out_line got=%b exp=0000", out_line); end
    checks++; if (out_none !== 1'b0) begin failures++; $display("FAIL reset_out_none got=%b exp=0", out_none); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (hit_cnt !== 40'd0) begin failures++; $display("FAIL reset_hit_cnt got=%h exp=0", hit_cnt); end
  endtask

  task automatic test_decode_all();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      send(1, i);
      step();
      checks++; if (out_valid !== 1'b1 || out_line !== exp_line[i] || out_none !== 1'b0)
        begin failures++; $display("FAIL decode_code%0d got v=%b line=%b none=%b exp v=1 line=%b none=0", i, out_valid, out_line, out_none, exp_line[i]); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL decode_in_ready%0d got=%b exp=1", i, in_ready); end
    end
    in_valid = 0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL decode_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_none();
    send(0, 3);
    step();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_line !== 4'b0000 || out_none !== 1'b1)
      begin failures++; $display("FAIL none_word got v=%b line=%b none=%b exp v=1 line=0000 none=1", out_valid, out_line, out_none); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL none_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    send(1, 1);
    step();
    checks++; if (out_line !== 4'b0010 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_first got line=%b rdy=%b exp 0010 1", out_line, in_ready); end
    send(1, 2);
    step();
    checks++; if (out_line !== 4'b0010 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_skid got line=%b rdy=%b exp 0010 0", out_line, in_ready); end
    send(1, 3);
    step();
    checks++; if (out_valid !== 1'b1 || out_line !== 4'b0010 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold got v=%b line=%b rdy=%b exp 1 0010 0", out_valid, out_line, in_ready); end
    out_ready = 1;
    step();
    checks++; if (out_valid !== 1'b1 || out_line !== 4'b0100 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_second got v=%b line=%b rdy=%b exp 1 0100 1", out_valid, out_line, in_ready); end
    step();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_line !== 4'b1000) begin failures++; $display("FAIL bp_third got v=%b line=%b exp 1 1000", out_valid, out_line); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    send(1, 0);
    step();
    send(1, 3);
    step();
    in_valid = 0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_full got rdy=%b exp=0", in_ready); end
    rst = 1;
    step();
    rst = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_line !== 4'b0000) begin failures++; $display("FAIL mid_reset got v=%b rdy=%b line=%b exp 0 1 0000", out_valid, in_ready, out_line); end
    out_ready = 1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_gone got v=%b exp=0", out_valid); end
  endtask

`ifdef PE_DEC_HIT_CNT_EN
  task automatic test_counters();
    out_ready = 1;
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    send(1, 2);
    repeat (300) step();
    in_valid = 0;
    step();
    checks++; if (hit_cnt[23:16] !== 8'd255) begin failures++; $display("FAIL cnt_sat got=%0d exp=255", hit_cnt[23:16]); end
    checks++; if (hit_cnt[7:0] !== 8'd0 || hit_cnt[39:32] !== 8'd0) begin failures++; $display("FAIL cnt_other got l0=%0d none=%0d exp 0 0", hit_cnt[7:0], hit_cnt[39:32]); end
    send(1, 2);
    step();
    in_valid = 0;
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    checks++; if (hit_cnt !== 40'd0) begin failures++; $display("FAIL cnt_clr got=%h exp=0", hit_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_decode_all();
    test_none();
    test_backpressure();
    test_reset_mid();
`ifdef PE_DEC_HIT_CNT_EN
    test_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
